nco_sweep_ctrl: RTL and testbench

Frequency-sweep (chirp) controller directly upstream of the NCO. Drives the NCO `step` (phase increment) input. Steps it from a start to a stop frequency in fixed increments, holding each value for a programmable dwell. Supports a one-shot sweep or a continuous triangle (up/down) sweep, with a start/busy/done handshake and abort.

---
 rtl/nco_sweep_ctrl.sv | 155 +++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Chirp controller that feeds the NCO phase increment. It runs either a one-shot
// up-sweep or a continuous triangle, and holds each step value for a programmable dwell.
module nco_sweep_ctrl #(
    parameter int STEP_SIZE   = 16,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode,
    input  logic [STEP_SIZE-1:0]   f_start,
    input  logic [STEP_SIZE-1:0]   f_stop,
    input  logic [STEP_SIZE-1:0]   f_inc,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [STEP_SIZE-1:0]   step,
    output logic                   step_upd,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t                 state_q, state_d;
    logic [STEP_SIZE-1:0]   step_q, step_d, fs_q, fs_d, stop_q, stop_d, inc_q, inc_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic                   mode_q, mode_d, upd_q, upd_d, busy_q, busy_d, done_q, done_d;

    logic [STEP_SIZE:0]     sum, diff;
    logic [STEP_SIZE-1:0]   up_tgt, dn_tgt, tgt;
    logic [DWELL_WIDTH-1:0] dwell_in_eff;
    logic                   expire, move;

    // Carry/borrow out of the extra MSB means the walk left the range, so clamp to the end point.
    assign sum    = {1'b0, step_q} + {1'b0, inc_q};
    assign diff   = {1'b0, step_q} - {1'b0, inc_q};
    assign up_tgt = (sum[STEP_SIZE] || (sum[STEP_SIZE-1:0] >= stop_q)) ? stop_q : sum[STEP_SIZE-1:0];
    assign dn_tgt = (diff[STEP_SIZE] || (diff[STEP_SIZE-1:0] <= fs_q)) ? fs_q : diff[STEP_SIZE-1:0];

    assign dwell_in_eff = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
    assign expire       = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fs_d    = fs_q;
        stop_d  = stop_q;
        inc_d   = inc_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        tgt     = step_q;
        move    = 1'b0;

        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            step_d  = '0;
            upd_d   = (step_q != '0);
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        fs_d    = f_start;
                        stop_d  = (f_stop > f_start) ? f_stop : f_start;
                        inc_d   = f_inc;
                        mode_d  = mode;
                        dwell_d = dwell_in_eff;
                        cnt_d   = dwell_in_eff - DWELL_WIDTH'(1);
                        step_d  = f_start;
                        upd_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = UP;
                    end
                end
                UP: begin
                    if (expire) begin
                        move = 1'b1;
                        if (step_q == stop_q) begin
                            if (!mode_q) begin
                                move    = 1'b0;
                                state_d = IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = DOWN;
                                tgt     = dn_tgt;
                            end
                        end else begin
                            tgt = up_tgt;
                        end
                    end
                end
                DOWN: begin
                    if (expire) begin
                        move = 1'b1;
                        if (step_q == fs_q) begin
                            state_d = UP;
                            tgt     = up_tgt;
                        end else begin
                            tgt = dn_tgt;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // A turnaround that lands on the same value (degenerate range) reloads without a pulse.
            if (move) begin
                step_d = tgt;
                upd_d  = (tgt != step_q);
                cnt_d  = dwell_q - DWELL_WIDTH'(1);
            end else if (state_q != IDLE && !expire) begin
                cnt_d = cnt_q - DWELL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            fs_q    <= '0;
            stop_q  <= '0;
            inc_q   <= '0;
            mode_q  <= 1'b0;
            dwell_q <= '0;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            fs_q    <= fs_d;
            stop_q  <= stop_d;
            inc_q   <= inc_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign step     = step_q;
    assign step_upd = upd_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed sweep scenarios, plus random sweeps checked
// against a value-list model of the chirp.
module tb_nco_sweep_ctrl;
    localparam int SW  = 16;
    localparam int DWW = 16;

    logic           clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, mode = 1'b0;
    logic [SW-1:0]  f_start = '0, f_stop = '0, f_inc = '0;
    logic [DWW-1:0] dwell = '0;
    logic [SW-1:0]  step;
    logic           step_upd, busy, done;
    int             errors = 0, checks = 0;

    nco_sweep_ctrl #(.STEP_SIZE(SW), .DWELL_WIDTH(DWW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .f_start(f_start), .f_stop(f_stop), .f_inc(f_inc), .dwell(dwell),
        .step(step), .step_upd(step_upd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a configuration with start for one edge; returns just after that edge (edge 0).
    task automatic kick(input int fs, input int fe, input int inc, input int dw, input logic md);
        f_start = SW'(fs);
        f_stop  = SW'(fe);
        f_inc   = SW'(inc);
        dwell   = DWW'(dw);
        mode    = md;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (step !== '0 || busy !== 1'b0 || done !== 1'b0 || step_upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_async step=%0d busy=%b done=%b upd=%b, want all zero", step, busy, done, step_upd);
        end
        #9 rst = 1'b1;
        tick();
        checks++;
        if (step !== '0 || busy !== 1'b0 || done !== 1'b0 || step_upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_release step=%0d busy=%b done=%b upd=%b, want all zero", step, busy, done, step_upd);
        end
    endtask

    task automatic test_single();
        int es;
        int npulse = 0;
        kick(100, 130, 10, 4, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            es = (k < 12) ? 100 + 10 * (k / 4) : 130;
            checks++;
            if (step !== SW'(es) || busy !== (k < 16) || done !== (k == 16) || step_upd !== (k < 16 && k % 4 == 0)) begin
                errors++;
                $display("FAIL single k=%0d step=%0d busy=%b done=%b upd=%b, want step=%0d", k, step, busy, done, step_upd, es);
            end
            if (step_upd) npulse++;
            tick();
        end
        checks++;
        if (npulse != 4) begin
            errors++;
            $display("FAIL single_pulses got=%0d want=4", npulse);
        end
    endtask

    task automatic test_overshoot();
        int es;
        kick(100, 130, 20, 4, 1'b0);
        for (int k = 0; k <= 14; k++) begin
            es = (k < 4) ? 100 : (k < 8) ? 120 : 130;
            checks++;
            if (step !== SW'(es) || busy !== (k < 12) || done !== (k == 12) || step_upd !== (k < 12 && k % 4 == 0)) begin
                errors++;
                $display("FAIL overshoot k=%0d step=%0d busy=%b done=%b upd=%b, want step=%0d", k, step, busy, done, step_upd, es);
            end
            tick();
        end
    endtask

    task automatic test_triangle();
        int per[4] = '{10, 20, 30, 20};
        kick(10, 30, 10, 1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (step !== SW'(per[k % 4]) || busy !== 1'b1 || done !== 1'b0 || step_upd !== 1'b1) begin
                errors++;
                $display("FAIL triangle k=%0d step=%0d busy=%b done=%b upd=%b, want step=%0d", k, step, busy, done, step_upd, per[k % 4]);
            end
            if (k < 11) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (step !== '0 || busy !== 1'b0 || done !== 1'b0 || step_upd !== 1'b1) begin
            errors++;
            $display("FAIL triangle_abort step=%0d busy=%b done=%b upd=%b, want 0/0/0/1", step, busy, done, step_upd);
        end
    endtask

    task automatic test_overflow();
        kick(32'hFFF0, 32'h0010, 32'h20, 3, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            checks++;
            if (step !== 16'hFFF0 || busy !== (k < 3) || done !== (k == 3) || step_upd !== (k == 0)) begin
                errors++;
                $display("FAIL overflow k=%0d step=%h busy=%b done=%b upd=%b, want step=fff0", k, step, busy, done, step_upd);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        kick(100, 130, 10, 4, 1'b0);
        repeat (6) tick();
        checks++;
        if (step !== 16'd110 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre step=%0d busy=%b, want 110/1", step, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (step !== '0 || busy !== 1'b0 || done !== 1'b0 || step_upd !== 1'b1) begin
            errors++;
            $display("FAIL abort_edge step=%0d busy=%b done=%b upd=%b, want 0/0/0/1", step, busy, done, step_upd);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (step !== '0 || busy !== 1'b0 || done !== 1'b0 || step_upd !== 1'b0) begin
                errors++;
                $display("FAIL abort_after k=%0d step=%0d busy=%b done=%b upd=%b, want all zero", k, step, busy, done, step_upd);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        f_start = 16'd55;
        f_stop  = 16'd80;
        f_inc   = 16'd5;
        dwell   = 16'd2;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (step !== '0 || busy !== 1'b0 || done !== 1'b0 || step_upd !== 1'b0) begin
                errors++;
                $display("FAIL start_abort k=%0d step=%0d busy=%b done=%b upd=%b, want all zero", k, step, busy, done, step_upd);
            end
            tick();
        end
    endtask

    task automatic test_start_busy();
        int es;
        kick(100, 130, 10, 4, 1'b0);
        for (int k = 0; k <= 17; k++) begin
            es = (k < 12) ? 100 + 10 * (k / 4) : 130;
            checks++;
            if (step !== SW'(es) || busy !== (k < 16) || done !== (k == 16) || step_upd !== (k < 16 && k % 4 == 0)) begin
                errors++;
                $display("FAIL start_busy k=%0d step=%0d busy=%b done=%b upd=%b, want step=%0d", k, step, busy, done, step_upd, es);
            end
            if (k == 5) begin
                f_start = 16'd999;
                f_stop  = 16'd2000;
                f_inc   = 16'd1;
                dwell   = 16'd1;
                mode    = 1'b1;
                start   = 1'b1;
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_inc_zero();
        kick(40, 90, 0, 2, 1'b0);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (step !== 16'd40 || busy !== 1'b1 || done !== 1'b0 || step_upd !== (k == 0)) begin
                errors++;
                $display("FAIL inc_zero k=%0d step=%0d busy=%b done=%b upd=%b, want step=40", k, step, busy, done, step_upd);
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        kick(100, 130, 10, 4, 1'b0);
        tick();
        tick();
        #3 rst = 1'b0;
        #1;
        checks++;
        if (step !== '0 || busy !== 1'b0 || done !== 1'b0 || step_upd !== 1'b0) begin
            errors++;
            $display("FAIL async_reset step=%0d busy=%b done=%b upd=%b, want all zero", step, busy, done, step_upd);
        end
        #2 rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (step !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d step=%0d busy=%b done=%b, want all zero", k, step, busy, done);
            end
        end
        kick(5, 8, 1, 0, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            checks++;
            if (step !== SW'((k < 4) ? 5 + k : 8) || busy !== (k < 4) || done !== (k == 4) || step_upd !== (k < 4)) begin
                errors++;
                $display("FAIL dwell_zero k=%0d step=%0d busy=%b done=%b upd=%b", k, step, busy, done, step_upd);
            end
            tick();
        end
    endtask

    // Model: list the step values a sweep visits (one triangle period for mode 1),
    // then expand each into dwell_eff cycles.
    task automatic test_random();
        int fs, fe, se, inc, dw, dwe, n, ncyc, lim, ev, pv, v;
        logic md, eb, ed, eu;
        int vals[$];
        for (int it = 0; it < 24; it++) begin
            if (it % 4 == 3) begin
                fs  = $urandom_range(65000, 65500);
                fe  = $urandom_range(64900, 65535);
                inc = $urandom_range(20, 400);
            end else begin
                fs  = $urandom_range(0, 200);
                fe  = $urandom_range(0, 300);
                inc = $urandom_range(1, 60);
            end
            dw  = $urandom_range(0, 3);
            md  = 1'($urandom_range(0, 1));
            se  = (fe > fs) ? fe : fs;
            dwe = (dw == 0) ? 1 : dw;
            vals.delete();
            v = fs;
            vals.push_back(v);
            while (v != se) begin
                v = (v + inc >= se) ? se : v + inc;
                vals.push_back(v);
            end
            if (md) begin
                v = se;
                while (v > fs) begin
                    v = (v <= fs + inc) ? fs : v - inc;
                    if (v != fs) vals.push_back(v);
                end
            end
            n    = vals.size();
            lim  = n * dwe * 2 + 3;
            ncyc = md ? ((lim < 200) ? lim : 200) : n * dwe + 2;
            pv   = -1;
            ev   = 0;
            kick(fs, fe, inc, dw, md);
            for (int t = 0; t < ncyc; t++) begin
                if (md) begin
                    ev = vals[(t / dwe) % n];
                    eb = 1'b1;
                    ed = 1'b0;
                    eu = (t % dwe == 0) && (ev != pv);
                end else if (t < n * dwe) begin
                    ev = vals[t / dwe];
                    eb = 1'b1;
                    ed = 1'b0;
                    eu = (t % dwe == 0);
                end else begin
                    ev = se;
                    eb = 1'b0;
                    ed = (t == n * dwe);
                    eu = 1'b0;
                end
                checks++;
                if (step !== SW'(ev) || busy !== eb || done !== ed || step_upd !== eu) begin
                    errors++;
                    $display("FAIL random it=%0d t=%0d step=%0d busy=%b done=%b upd=%b, want %0d/%b/%b/%b",
                             it, t, step, busy, done, step_upd, ev, eb, ed, eu);
                end
                pv = ev;
                if (t < ncyc - 1) tick();
            end
            if (md) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                checks++;
                if (step !== '0 || busy !== 1'b0 || done !== 1'b0 || step_upd !== (ev != 0)) begin
                    errors++;
                    $display("FAIL random_abort it=%0d step=%0d busy=%b done=%b upd=%b", it, step, busy, done, step_upd);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overshoot();
        test_triangle();
        test_overflow();
        test_abort();
        test_start_abort_idle();
        test_start_busy();
        test_inc_zero();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
